sr_latch_driver: RTL

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_drv_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/sr_latch_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sr_drv_pkg.sv
// Shared encodings and defaults for the NAND-latch pulse driver.
package sr_drv_pkg;

    localparam int PULSE_W_DEF = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W       = $clog2(255 + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } drv_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Pulses the active-low set/reset inputs of an external NAND latch and
// confirms the result through synchronized Q/Qbar readback.
//
// state | meaning
// IDLE  | ready for a command, both drives released
// DRIVE | one drive held low for PULSE_W cycles
// WAIT  | drives released, waiting up to TIMEOUT cycles for readback match
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = PULSE_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic Sbar,
    output logic Rbar,
    input  logic Q_in,
    input  logic Qbar_in,
    output logic busy,
    output logic done,
    output logic err,
    output logic q_sync
);

    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    drv_state_e       state, state_nx;
    logic             set_r, set_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             qbar_sync;
    logic             match;
    logic             done_nx, err_nx;
    logic             ready_nx, busy_nx, sbar_nx, rbar_nx;

    sync_2ff u_sync_q (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (Q_in),
        .q       (q_sync)
    );

    sync_2ff u_sync_qbar (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (Qbar_in),
        .q       (qbar_sync)
    );

    // Q == Qbar can never satisfy this, so an invalid latch reads as no match.
    assign match = (q_sync == set_r) && (qbar_sync == ~set_r);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            set_r     <= 1'b0;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            Sbar      <= 1'b1;
            Rbar      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            set_r     <= set_nx;
            cnt       <= cnt_nx;
            cmd_ready <= ready_nx;
            busy      <= busy_nx;
            Sbar      <= sbar_nx;
            Rbar      <= rbar_nx;
            done      <= done_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        set_nx   = set_r;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nx = DRIVE;
                    set_nx   = cmd_set;
                    cnt_nx   = PULSE_LOAD;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_nx = WAIT;
                    cnt_nx   = TIMEOUT_LOAD;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            WAIT: begin
                // A match on the final timeout cycle still wins over err.
                if (match) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (cnt == '0) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        ready_nx = 1'b1;
        busy_nx  = 1'b0;
        sbar_nx  = 1'b1;
        rbar_nx  = 1'b1;
        case (state_nx)
            DRIVE: begin
                ready_nx = 1'b0;
                busy_nx  = 1'b1;
                if (set_nx) begin
                    sbar_nx = 1'b0;
                end else begin
                    rbar_nx = 1'b0;
                end
            end
            WAIT: begin
                ready_nx = 1'b0;
                busy_nx  = 1'b1;
            end
            default: begin
                ready_nx = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule
